// File: rtl/apb_resp_pkg.sv
// Shared definitions for the APB register responder.
// Contents:
//   - FSM state encoding (the localparams and the enum that uses them)
//   - Bit positions inside the latched error-cause vector
//   - idx_width(): width of a register index for a given register count
package apb_resp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP
  } state_e;

  localparam int ERR_ALIGN = 0;
  localparam int ERR_RANGE = 1;
  localparam int ERR_RO    = 2;
  localparam int ERR_W     = 3;

  // A single register still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder for the APB register responder.
// Ports:
//   paddr  in   byte address from the bus
//   pwrite in   transfer direction, needed for the read-only check
//   idx    out  register index (halfword offset from BASE_ADDR)
//   err    out  error causes, bit positions ERR_ALIGN/ERR_RANGE/ERR_RO
module apb_addr_decode
  import apb_resp_pkg::*;
#(
  parameter int                   ADDR_W    = 20,
  parameter int                   NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
  parameter int                   IW        = idx_width(NUM_REGS)
) (
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  output logic [IW-1:0]     idx,
  output logic [ERR_W-1:0]  err
);

  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(2 * NUM_REGS);

  logic [ADDR_W-1:0]   off;
  logic [(2**IW)-1:0]  mask_pad;
  logic                in_range;

  // Zero-extend the mask so every index value selects a defined bit.
  assign mask_pad = (2**IW)'(RO_MASK);

  assign off      = paddr - BASE_ADDR;
  assign idx      = off[IW:1];
  assign in_range = (paddr >= BASE_ADDR) && ({1'b0, off} < SPAN);

  assign err[ERR_ALIGN] = paddr[0];
  assign err[ERR_RANGE] = !in_range;
  assign err[ERR_RO]    = pwrite && in_range && mask_pad[idx];

endmodule

// File: rtl/apb_reg_responder.sv
// APB completer holding a bank of 16-bit registers.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   psel, penable       APB select / access phase
//   pwrite, pstrb       direction and byte-lane strobes
//   paddr, pwdata       byte address and write data
//   pready              one-cycle transfer completion
//   prdata, pslverr     read data and error, valid only with pready
//   ro_data             live values for read-only registers
//   regs_o              writable register contents (read-only slices are 0)
//   wr_pulse            one-cycle pulse per register after a committed write
module apb_reg_responder
  import apb_resp_pkg::*;
#(
  parameter int                   ADDR_W      = 20,
  parameter int                   DATA_W      = 16,
  parameter int                   NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
  parameter int                   WAIT_CYCLES = 1,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [1:0]                   pstrb,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  output logic                         pready,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pslverr,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_data,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int IW = idx_width(NUM_REGS);

  state_e              state, state_nxt;
  logic [3:0]          cnt;
  logic [IW-1:0]       dec_idx, idx_lat;
  logic [ERR_W-1:0]    dec_err, err_lat;
  logic                wr_lat;
  logic [1:0]          strb_lat;
  logic [DATA_W-1:0]   wdata_lat;
  logic [DATA_W-1:0]   regs   [NUM_REGS];
  logic [DATA_W-1:0]   ro_arr [NUM_REGS];
  logic [(2**IW)-1:0]  mask_pad;
  logic [DATA_W-1:0]   rd_val;
  logic                accept, commit;

  apb_addr_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .RO_MASK   (RO_MASK),
    .IW        (IW)
  ) u_decode (
    .paddr  (paddr),
    .pwrite (pwrite),
    .idx    (dec_idx),
    .err    (dec_err)
  );

  assign mask_pad = (2**IW)'(RO_MASK);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slices
    assign ro_arr[i]                     = ro_data[i*DATA_W +: DATA_W];
    assign regs_o[i*DATA_W +: DATA_W]    = RO_MASK[i] ? '0 : regs[i];
  end

  // Any psel in IDLE is taken as setup, including a premature penable=1.
  assign accept = (state == S_IDLE) && psel;
  assign commit = (state == S_RESP) && wr_lat && !(|err_lat);

  // ---- FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (psel) state_nxt = S_WAIT;
      S_WAIT: begin
        if (!psel)                       state_nxt = S_IDLE;
        else if (penable && cnt == 4'd0) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Wait-state counter only advances during the access phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= 4'(WAIT_CYCLES);
    end else if (state == S_WAIT && penable && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // ---- setup capture ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_lat <= '0;
      wr_lat  <= 1'b0;
    end else if (accept) begin
      err_lat <= dec_err;
      wr_lat  <= pwrite;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_lat   <= dec_idx;
      strb_lat  <= pstrb;
      wdata_lat <= pwdata;
    end
  end

  // ---- register bank / commit ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        if (strb_lat[0]) regs[idx_lat][7:0]  <= wdata_lat[7:0];
        if (strb_lat[1]) regs[idx_lat][15:8] <= wdata_lat[15:8];
        wr_pulse[idx_lat] <= 1'b1;
      end
    end
  end

  // ---- response ----
  assign rd_val  = mask_pad[idx_lat] ? ro_arr[idx_lat] : regs[idx_lat];
  assign pready  = (state == S_RESP);
  assign pslverr = (state == S_RESP) && (|err_lat);
  assign prdata  = ((state == S_RESP) && !(|err_lat)) ? rd_val : '0;

endmodule

// File: tb/tb_apb_reg_responder.sv
module tb_apb_reg_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        psel[2], penable[2], pwrite[2];
  logic [1:0]  pstrb[2];
  logic [19:0] paddr[2];
  logic [15:0] pwdata[2];
  logic        pready[2], pslverr[2];
  logic [15:0] prdata[2];
  logic [255:0] ro0, regs0;
  logic [15:0]  wp0;
  logic [127:0] ro1, regs1;
  logic [7:0]   wp1;

  // dut0: 16 regs at 0x00000, 1 wait state, register 0 read-only
  apb_reg_responder #(
    .ADDR_W(20), .DATA_W(16), .NUM_REGS(16), .BASE_ADDR(20'h00000),
    .WAIT_CYCLES(1), .RO_MASK(16'h0001)
  ) dut0 (
    .clk(clk), .reset(reset), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .pstrb(pstrb[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
    .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]),
    .ro_data(ro0), .regs_o(regs0), .wr_pulse(wp0)
  );

  // dut1: 8 regs at 0x00100, 3 wait states, nothing read-only
  apb_reg_responder #(
    .ADDR_W(20), .DATA_W(16), .NUM_REGS(8), .BASE_ADDR(20'h00100),
    .WAIT_CYCLES(3), .RO_MASK(8'h00)
  ) dut1 (
    .clk(clk), .reset(reset), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .pstrb(pstrb[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
    .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]),
    .ro_data(ro1), .regs_o(regs1), .wr_pulse(wp1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model of dut0: plain array of register values.
  logic [15:0] m0 [16];

  task automatic model0(input bit wr, input logic [19:0] a, input logic [15:0] d,
                        input logic [1:0] s, output bit e, output logic [15:0] rd,
                        output logic [15:0] wp);
    int ai;
    int r;
    ai = int'(a);
    r  = ai / 2;
    e  = (ai % 2 != 0) || (ai >= 32) || (wr && r == 0);
    rd = 16'h0;
    wp = 16'h0;
    if (!e) begin
      rd = (r == 0) ? 16'h4552 : m0[r];
      if (wr) begin
        if (s[0]) m0[r][7:0]  = d[7:0];
        if (s[1]) m0[r][15:8] = d[15:8];
        wp = 16'h1 << r;
      end
    end
  endtask

  function automatic logic [255:0] pack0();
    logic [255:0] p;
    for (int i = 0; i < 16; i++) p[i*16 +: 16] = (i == 0) ? 16'h0 : m0[i];
    return p;
  endfunction

  // One complete transfer. Returns with the bus idle, one cycle after RESP.
  task automatic xfer(input int d, input bit lead, input bit viol, input bit drop,
                      input bit wr, input logic [19:0] a, input logic [15:0] wd,
                      input logic [1:0] s, output int lat, output logic [15:0] rd,
                      output logic e);
    if (lead) begin @(posedge clk); #1; end
    psel[d] = 1'b1; penable[d] = viol; pwrite[d] = wr;
    paddr[d] = a; pwdata[d] = wd; pstrb[d] = s;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    lat = 1;
    while (!pready[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = prdata[d];
    e  = pslverr[d];
    if (drop) begin psel[d] = 1'b0; penable[d] = 1'b0; end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [19:0] a;
    logic [15:0] d;
    logic [1:0]  s;
    logic [15:0] erd;
    bit          eerr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int lat;
    logic [15:0] rd, mrd, mwp;
    logic e;
    bit me;
    bit seen_rdy;
    logic [7:0] wp_acc;

    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [15:0] rd, mrd, mwp;
    logic e;
    bit me, wr, lead, drop;
    bit seen_rdy;
    logic [7:0] wp_acc;
    logic [19:0] a;
    logic [15:0] d;
    logic [1:0] s;

    tbl[0]  = '{1'b1, 20'h00004, 16'hBEEF, 2'b11, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 20'h00004, 16'h0000, 2'b00, 16'hBEEF, 1'b0};
    tbl[2]  = '{1'b1, 20'h00006, 16'hAAAA, 2'b11, 16'h0000, 1'b0};
    tbl[3]  = '{1'b1, 20'h00006, 16'h1234, 2'b01, 16'hAAAA, 1'b0};
    tbl[4]  = '{1'b0, 20'h00006, 16'h0000, 2'b00, 16'hAA34, 1'b0};
    tbl[5]  = '{1'b1, 20'h00006, 16'h5678, 2'b00, 16'hAA34, 1'b0};
    tbl[6]  = '{1'b0, 20'h00006, 16'h0000, 2'b00, 16'hAA34, 1'b0};
    tbl[7]  = '{1'b0, 20'h00003, 16'h0000, 2'b00, 16'h0000, 1'b1};
    tbl[8]  = '{1'b0, 20'h00020, 16'h0000, 2'b00, 16'h0000, 1'b1};
    tbl[9]  = '{1'b1, 20'h00000, 16'hFFFF, 2'b11, 16'h0000, 1'b1};
    tbl[10] = '{1'b0, 20'h00000, 16'h0000, 2'b00, 16'h4552, 1'b0};
    tbl[11] = '{1'b1, 20'h00005, 16'h9999, 2'b11, 16'h0000, 1'b1};
    tbl[12] = '{1'b0, 20'h00004, 16'h0000, 2'b00, 16'hBEEF, 1'b0};

    for (int i = 0; i < 16; i++) m0[i] = 16'h0;
    ro0 = {16{16'hDEAD}};
    ro0[15:0] = 16'h4552;
    ro1 = {8{16'h7777}};
    for (int k = 0; k < 2; k++) begin
      psel[k] = 0; penable[k] = 0; pwrite[k] = 0;
      pstrb[k] = 0; paddr[k] = 0; pwdata[k] = 0;
    end

    // reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst pready",   256'(pready[0]),  256'(0));
    chk("rst pslverr",  256'(pslverr[0]), 256'(0));
    chk("rst prdata",   256'(prdata[0]),  256'(0));
    chk("rst regs_o",   regs0,            256'(0));
    chk("rst wr_pulse", 256'(wp0),        256'(0));
    @(negedge clk);
    reset = 1'b0;

    // directed table on dut0
    for (int i = 0; i < 13; i++) begin
      xfer(0, 1'b1, 1'b0, 1'b0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, lat, rd, e);
      model0(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, me, mrd, mwp);
      chk($sformatf("tbl%0d latency", i),  256'(lat), 256'(3));
      chk($sformatf("tbl%0d pslverr", i),  256'(e),   256'(tbl[i].eerr));
      chk($sformatf("tbl%0d prdata", i),   256'(rd),  256'(tbl[i].erd));
      chk($sformatf("tbl%0d wr_pulse", i), 256'(wp0), 256'(mwp));
      chk($sformatf("tbl%0d regs_o", i),   regs0,     pack0());
      chk($sformatf("tbl%0d pready drop", i), 256'(pready[0]), 256'(0));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d wr_pulse end", i), 256'(wp0), 256'(0));
    end

    // setup with penable already high is still taken as setup
    xfer(0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00004, 16'h0, 2'b00, lat, rd, e);
    chk("viol latency", 256'(lat), 256'(3));
    chk("viol prdata",  256'(rd),  256'(16'hBEEF));

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      wr   = 1'($urandom_range(0, 1));
      a    = 20'($urandom_range(0, 39));
      d    = 16'($urandom);
      s    = 2'($urandom_range(0, 3));
      lead = ($urandom_range(0, 3) != 0);
      drop = ($urandom_range(0, 2) == 0);
      xfer(0, lead, 1'b0, drop, wr, a, d, s, lat, rd, e);
      model0(wr, a, d, s, me, mrd, mwp);
      chk($sformatf("rnd%0d latency a=%0h", n, a),  256'(lat), 256'(3));
      chk($sformatf("rnd%0d pslverr a=%0h", n, a),  256'(e),   256'(me));
      chk($sformatf("rnd%0d prdata a=%0h", n, a),   256'(rd),  256'(mrd));
      chk($sformatf("rnd%0d wr_pulse a=%0h", n, a), 256'(wp0), 256'(mwp));
      chk($sformatf("rnd%0d regs_o a=%0h", n, a),   regs0,     pack0());
    end

    // dut1: plain write with 3 wait states
    xfer(1, 1'b1, 1'b0, 1'b0, 1'b1, 20'h00102, 16'h1111, 2'b11, lat, rd, e);
    chk("d1 wr latency",  256'(lat), 256'(5));
    chk("d1 wr pslverr",  256'(e),   256'(0));
    chk("d1 wr_pulse",    256'(wp1), 256'(8'h02));
    chk("d1 reg1",        256'(regs1[31:16]), 256'(16'h1111));

    // abort in WAIT: psel drops before the counter expires
    @(posedge clk); #1;
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1;
    paddr[1] = 20'h00102; pwdata[1] = 16'h2222; pstrb[1] = 2'b11;
    @(posedge clk); #1;
    penable[1] = 1;
    @(posedge clk); #1;
    psel[1] = 0; penable[1] = 0;
    seen_rdy = 0;
    wp_acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      seen_rdy = seen_rdy | pready[1];
      wp_acc   = wp_acc | wp1;
    end
    chk("abort pready",   256'(seen_rdy), 256'(0));
    chk("abort wr_pulse", 256'(wp_acc),   256'(0));
    chk("abort reg1",     256'(regs1[31:16]), 256'(16'h1111));

    // back-to-back reads with no idle gap
    xfer(1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00102, 16'h0, 2'b00, lat, rd, e);
    chk("b2b rd1 latency", 256'(lat), 256'(5));
    chk("b2b rd1 prdata",  256'(rd),  256'(16'h1111));
    xfer(1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00104, 16'h0, 2'b00, lat, rd, e);
    chk("b2b rd2 latency", 256'(lat), 256'(5));
    chk("b2b rd2 prdata",  256'(rd),  256'(16'h0000));
    chk("b2b rd2 pslverr", 256'(e),   256'(0));

    // base-relative range limits
    xfer(1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00110, 16'h0, 2'b00, lat, rd, e);
    chk("d1 above range pslverr", 256'(e),  256'(1));
    chk("d1 above range prdata",  256'(rd), 256'(0));
    xfer(1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h000FE, 16'h0, 2'b00, lat, rd, e);
    chk("d1 below base pslverr",  256'(e),  256'(1));
    xfer(1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0010E, 16'h0, 2'b00, lat, rd, e);
    chk("d1 last reg pslverr",    256'(e),  256'(0));

    // reset during WAIT of a write
    @(posedge clk); #1;
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1;
    paddr[1] = 20'h00104; pwdata[1] = 16'h3333; pstrb[1] = 2'b11;
    @(posedge clk); #1;
    penable[1] = 1;
    #2 reset = 1'b1;
    #1;
    chk("mid rst pready",   256'(pready[1]),  256'(0));
    chk("mid rst pslverr",  256'(pslverr[1]), 256'(0));
    chk("mid rst prdata",   256'(prdata[1]),  256'(0));
    chk("mid rst regs_o",   256'(regs1),      256'(0));
    chk("mid rst wr_pulse", 256'(wp1),        256'(0));
    psel[1] = 0; penable[1] = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    xfer(1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00104, 16'h0, 2'b00, lat, rd, e);
    chk("post rst latency", 256'(lat), 256'(5));
    chk("post rst prdata",  256'(rd),  256'(16'h0000));
    chk("post rst regs_o",  256'(regs1), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
